// File: rtl/accumulator_scheduler.sv
// Request FIFO plus issue FSM feeding one row update at a time into the NNUE accumulator.
// Optional wait-for-finish watchdog enabled by defining ACC_SCHED_TIMEOUT_EN.
module accumulator_scheduler #(
   parameter int ROW_W       = 7,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ROW_W-1:0]           req_row,
   input  logic                       req_add,
   input  logic                       flush,
   output logic [ROW_W-1:0]           acc_row,
   output logic                       acc_add,
   output logic                       acc_trigger,
   input  logic                       acc_finish,
   output logic                       busy,
   output logic                       batch_done,
   output logic [$clog2(DEPTH):0]     pending,
   output logic                       err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("accumulator_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state;
   logic [ROW_W:0]   mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;
   logic [ROW_W:0]   head;
   logic             fifo_full;
   logic             fifo_has;
   logic             push;
   logic             pop;
   logic             timeout;

   assign fifo_full = (count == CNT_W'(DEPTH));
   assign req_ready = !rst && !fifo_full;
   // flush discards a same-cycle push and blocks a same-cycle pop
   assign push      = req_valid && req_ready && !flush;
   assign fifo_has  = (count != '0) && !flush;
   assign head      = mem[rptr];
   assign pending   = count;
   assign busy      = (state != IDLE) || (count != '0);

   assign pop = fifo_has && ((state == IDLE) ||
                             ((state == WAIT) && (acc_finish || timeout)));

`ifdef ACC_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wait_cnt;

   assign timeout = (state == WAIT) && !acc_finish && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {req_row, req_add};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The head is latched into acc_row/acc_add on the same edge it leaves the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc_row     <= '0;
         acc_add     <= 1'b0;
         acc_trigger <= 1'b0;
         batch_done  <= 1'b0;
      end else begin
         acc_trigger <= 1'b0;
         batch_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  state       <= ISSUE;
                  acc_trigger <= 1'b1;
                  {acc_row, acc_add} <= head;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (acc_finish || timeout) begin
                  if (pop) begin
                     state       <= ISSUE;
                     acc_trigger <= 1'b1;
                     {acc_row, acc_add} <= head;
                  end else begin
                     state      <= IDLE;
                     batch_done <= acc_finish;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_scheduler.sv
// Bench for accumulator_scheduler: queue-based reference model, scoreboard of expected issues,
// directed scenarios followed by randomized push/finish/flush traffic.
module tb_accumulator_scheduler;

   localparam int ROW_W = 7;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [ROW_W-1:0] req_row = '0;
   logic             req_add = 1'b0;
   logic             flush = 1'b0;
   logic [ROW_W-1:0] acc_row;
   logic             acc_add;
   logic             acc_trigger;
   logic             acc_finish = 1'b0;
   logic             busy;
   logic             batch_done;
   logic [$clog2(DEPTH):0] pending;
   logic             err;

   accumulator_scheduler #(.ROW_W(ROW_W), .DEPTH(DEPTH), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_row(req_row), .req_add(req_add), .flush(flush),
      .acc_row(acc_row), .acc_add(acc_add), .acc_trigger(acc_trigger),
      .acc_finish(acc_finish), .busy(busy), .batch_done(batch_done),
      .pending(pending), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int trig_cnt = 0;
   int bd_cnt   = 0;

   // Reference model: mq = ops waiting in the FIFO, sb = ops predicted to be issued
   logic [ROW_W:0] mq[$];
   logic [ROW_W:0] sb[$];
   logic [ROW_W:0] last_op;
   bit m_inflight, m_issuing, exp_trig, exp_bd;
   bit m_fin, m_start, m_acc;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         sb.delete();
         m_inflight = 0;
         m_issuing  = 0;
         exp_trig   = 0;
         exp_bd     = 0;
      end else begin
         m_fin   = m_inflight && !m_issuing && acc_finish;
         m_start = !flush && (mq.size() != 0) && (!m_inflight || m_fin);
         m_acc   = req_valid && (mq.size() < DEPTH) && !flush;
         if (m_start) sb.push_back(mq.pop_front());
         if (flush) mq.delete();
         if (m_acc) mq.push_back({req_row, req_add});
         exp_trig  = m_start;
         exp_bd    = m_fin && !m_start;
         m_issuing = m_start;
         if (m_start) m_inflight = 1;
         else if (m_fin) m_inflight = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         last_op = '0;
      end else begin
         chk("trigger", int'(acc_trigger), int'(exp_trig));
         if (acc_trigger) begin
            trig_cnt++;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL issue_order: got trigger row %0d with no op expected at %0t", acc_row, $time);
            end else begin
               last_op = sb.pop_front();
            end
         end
         chk("acc_op", int'({acc_row, acc_add}), int'(last_op));
         chk("batch_done", int'(batch_done), int'(exp_bd));
         if (batch_done) bd_cnt++;
         chk("pending", int'(pending), mq.size());
         chk("req_ready", int'(req_ready), int'(mq.size() < DEPTH));
         chk("busy", int'(busy), int'(m_inflight || (mq.size() != 0)));
         chk("err", int'(err), 0);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int row, input bit add);
      req_valid = 1'b1;
      req_row   = ROW_W'(row);
      req_add   = add;
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic pulse_finish();
      acc_finish = 1'b1;
      cyc();
      acc_finish = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, b0;
      // Reset
      cyc(3);
      chk("rst_trigger", int'(acc_trigger), 0);
      chk("rst_row", int'(acc_row), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_batch_done", int'(batch_done), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      cyc();
      chk("rst_ready", int'(req_ready), 1);

      // Single op: trigger two cycles after the push, row held until finish
      push(5, 1'b1);
      chk("lat1_trigger", int'(acc_trigger), 0);
      cyc();
      chk("lat2_trigger", int'(acc_trigger), 1);
      chk("lat2_row", int'(acc_row), 5);
      chk("lat2_add", int'(acc_add), 1);
      cyc(3);
      chk("hold_row", int'(acc_row), 5);
      pulse_finish();
      chk("single_batch_done", int'(batch_done), 1);
      chk("single_busy", int'(busy), 0);

      // Back-to-back
      t0 = trig_cnt; b0 = bd_cnt;
      push(1, 1'b1); push(2, 1'b0); push(3, 1'b1);
      repeat (3) begin cyc(3); pulse_finish(); end
      cyc(3);
      chk("b2b_triggers", trig_cnt - t0, 3);
      chk("b2b_batches", bd_cnt - b0, 1);

      // Backpressure with a stalled accumulator
      t0 = trig_cnt; b0 = bd_cnt;
      for (int i = 0; i < DEPTH + 2; i++) begin
         req_valid = 1'b1;
         req_row   = ROW_W'(20 + i);
         req_add   = i[0];
         cyc();
      end
      req_valid = 1'b0;
      chk("bp_pending", int'(pending), DEPTH);
      chk("bp_ready", int'(req_ready), 0);
      repeat (DEPTH + 3) begin cyc(2); pulse_finish(); end
      cyc(3);
      chk("bp_triggers", trig_cnt - t0, DEPTH + 1);
      chk("bp_batches", bd_cnt - b0, 1);

      // Flush with one op in flight
      t0 = trig_cnt; b0 = bd_cnt;
      for (int i = 0; i < 5; i++) push(40 + i, 1'b0);
      chk("fl_pre_pending", int'(pending), 4);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("fl_pending", int'(pending), 0);
      cyc(2);
      pulse_finish();
      chk("fl_batch_done", int'(batch_done), 1);
      cyc(5);
      chk("fl_triggers", trig_cnt - t0, 1);
      chk("fl_batches", bd_cnt - b0, 1);

      // Withheld finish: no watchdog in this build, so the op waits indefinitely
      push(9, 1'b1);
      cyc(100);
      chk("stall_busy", int'(busy), 1);
      chk("stall_err", int'(err), 0);
      pulse_finish();
      cyc(3);

      // Randomized traffic
      repeat (3000) begin
         req_valid  = 1'($urandom_range(0, 1));
         req_row    = ROW_W'($urandom);
         req_add    = 1'($urandom);
         acc_finish = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 49) == 0);
         cyc();
      end
      req_valid = 1'b0; acc_finish = 1'b0; flush = 1'b0;
      repeat (DEPTH + 4) begin cyc(2); pulse_finish(); end
      cyc(3);
      chk("drain_busy", int'(busy), 0);
      chk("drain_scoreboard", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
